instr_encoder: RTL and testbench

Inverse of the immediate generator: takes decoded instruction fields (format, opcode, funct3/funct7, register indices, full-width immediate) and packs them into a 32-bit RV32I instruction word. It sits between the test/loader front end and instruction memory. It checks immediate range and alignment, stamps each word with a running word address, and hands it downstream over a valid/ready handshake with one output register stage.

---
 rtl/instr_encoder.sv | 127 ++++++++++++
 tb/tb_instr_encoder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I instruction packer: fields in, 32-bit word out with range/alignment
// checks, running word address and one registered valid/ready output stage.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic        clear_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic [7:0]  err_count_o
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  ec_q, ec_d;

  logic [31:0] word_enc;
  logic        word_err;
  logic [31:0] cnt_src;
  logic        in_xfer, out_xfer;
  logic signed [31:0] imm_s;

  assign imm_s      = imm_i;
  assign in_ready_o = !valid_q || out_ready_i;
  assign in_xfer    = in_valid_i && in_ready_o;
  assign out_xfer   = valid_q && out_ready_i;

  // Out-of-range immediates are still packed (truncated); only err flags them.
  always_comb begin
    word_enc = NOP;
    word_err = 1'b1;
    case (fmt_i)
      FMT_R: begin
        word_enc = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        word_err = 1'b0;
      end
      FMT_I: begin
        word_enc = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        word_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      FMT_S: begin
        word_enc = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        word_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      FMT_B: begin
        word_enc = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                    imm_i[4:1], imm_i[11], opcode_i};
        word_err = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || imm_i[0];
      end
      FMT_U: begin
        word_enc = {imm_i[31:12], rd_i, opcode_i};
        word_err = (imm_i[11:0] != 12'd0);
      end
      FMT_J: begin
        word_enc = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        word_err = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || imm_i[0];
      end
      default: ;
    endcase
  end

  // clear rebases the counter before a coincident capture takes its address.
  always_comb begin
    cnt_src = clear_i ? BASE_ADDR : cnt_q;
    cnt_d   = in_xfer ? cnt_src + 32'd4 : cnt_src;
    addr_d  = in_xfer ? cnt_src : addr_q;
    instr_d = in_xfer ? word_enc : instr_q;
    err_d   = in_xfer ? word_err : err_q;
    valid_d = in_xfer ? 1'b1 : (out_xfer ? 1'b0 : valid_q);
    ec_d    = ec_q;
    if (clear_i) begin
      ec_d = 8'd0;
    end else if (out_xfer && err_q && (ec_q != 8'hFF)) begin
      ec_d = ec_q + 8'd1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      addr_q  <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= BASE_ADDR;
      ec_q    <= 8'd0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      ec_q    <= ec_d;
    end
  end

  assign out_valid_o = valid_q;
  assign instr_o     = instr_q;
  assign addr_o      = addr_q;
  assign err_o       = err_q;
  assign err_count_o = ec_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed encodings plus randomized traffic scored
// against an arithmetic reference model of the packing and checking rules.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clock, reset_n, clear, in_valid, in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        out_valid, out_ready, err;
  logic [31:0] instr, addr;
  logic [7:0]  err_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_cnt;
  int          m_ec;

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clock_i(clock), .reset_n_i(reset_n), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .fmt_i(fmt), .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
    .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .instr_o(instr), .addr_o(addr), .err_o(err), .err_count_o(err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: fields placed with shifts/masks, ranges checked as integers.
  function automatic void ref_encode(input logic [2:0] f, input logic [6:0] op,
                                     input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [4:0] rd_, input logic [4:0] rs1_,
                                     input logic [4:0] rs2_, input logic [31:0] u,
                                     output logic [31:0] w, output logic e);
    longint v;
    logic [31:0] base;
    v    = longint'($signed(u));
    base = 32'(op) | (32'(rd_) << 7) | (32'(f3) << 12) | (32'(rs1_) << 15) | (32'(rs2_) << 20);
    case (f)
      3'd0: begin w = base | (32'(f7) << 25); e = 1'b0; end
      3'd1: begin
        w = (base & ~(32'h1F << 20)) | ((u & 32'hFFF) << 20);
        e = (v < -2048) || (v > 2047);
      end
      3'd2: begin
        w = (base & ~(32'h1F << 7)) | (((u >> 5) & 32'h7F) << 25) | ((u & 32'h1F) << 7);
        e = (v < -2048) || (v > 2047);
      end
      3'd3: begin
        w = (base & ~(32'h1F << 7)) | (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25)
            | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7);
        e = (v < -4096) || (v > 4094) || ((u % 2) != 0);
      end
      3'd4: begin
        w = (32'(op) | (32'(rd_) << 7)) | (u & 32'hFFFF_F000);
        e = (u % 4096) != 0;
      end
      3'd5: begin
        w = (32'(op) | (32'(rd_) << 7)) | (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
            | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12);
        e = (v < -1048576) || (v > 1048574) || ((u % 2) != 0);
      end
      default: begin w = 32'h0000_0013; e = 1'b1; end
    endcase
  endfunction

  // Scoreboard: observe mid-cycle, predict what the next rising edge does.
  always @(negedge clock) begin
    if (!reset_n) begin
      sb.delete();
      m_cnt = BASE;
      m_ec  = 0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
    end else begin
      chk("err_count", 32'(err_count), 32'(m_ec));
      chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid) begin
        chk("sb_occupancy", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
          chk("sb_instr", instr, sb[0].instr);
          chk("sb_addr", addr, sb[0].addr);
          chk("sb_err", 32'(err), 32'(sb[0].err));
        end
      end else begin
        chk("sb_idle", 32'(sb.size()), 32'd0);
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        if (sb[0].err && m_ec < 255) m_ec++;
        void'(sb.pop_front());
      end
      if (clear) m_ec = 0;
      if (in_valid && in_ready) begin
        exp_t x;
        ref_encode(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, x.instr, x.err);
        x.addr = clear ? BASE : m_cnt;
        m_cnt  = x.addr + 32'd4;
        sb.push_back(x);
      end else if (clear) begin
        m_cnt = BASE;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd_, input logic [4:0] rs1_,
                       input logic [4:0] rs2_, input logic [31:0] im);
    fmt = f; opcode = op; funct3 = f3; funct7 = f7;
    rd = rd_; rs1 = rs1_; rs2 = rs2_; imm = im;
    in_valid = 1'b1;
  endtask

  function automatic logic [31:0] pick_imm();
    logic [31:0] edges [14];
    edges = '{32'd5, -32'sd2048, 32'd2047, 32'd2048, -32'sd2049, -32'sd4096, 32'd4094,
              32'd4095, 32'd4096, -32'sd1048576, 32'd1048574, 32'd1048576,
              32'h0001_2000, 32'h0001_2001};
    case ($urandom_range(0, 3))
      0: return edges[$urandom_range(0, 13)];
      1: return $urandom;
      2: return 32'($urandom_range(0, 8191)) - 32'd4096;
      default: return $urandom & 32'hFFFF_F000;
    endcase
  endfunction

  initial begin
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    fmt = 0; opcode = 0; funct3 = 0; funct7 = 0; rd = 0; rs1 = 0; rs2 = 0; imm = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ec", 32'(err_count), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    drive(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    tick(); in_valid = 1'b0;
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_instr", instr, 32'h0050_0093);
    chk("addi_addr", addr, 32'd0);
    chk("addi_err", 32'(err), 32'd0);
    clear = 1'b1; tick(); clear = 1'b0;

    drive(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd5, 32'd12);
    tick();
    chk("sw_instr", instr, 32'h0050_A623);
    chk("sw_addr", addr, 32'd0);
    drive(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd4);
    tick();
    chk("beq_instr", instr, 32'hFE00_0EE3);
    chk("beq_addr", addr, 32'd4);
    drive(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);
    tick();
    chk("jal_instr", instr, 32'h0080_00EF);
    chk("jal_err", 32'(err), 32'd0);
    drive(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd9);
    tick(); in_valid = 1'b0;
    chk("jal_odd_err", 32'(err), 32'd1);
    tick();
    chk("jal_odd_ec", 32'(err_count), 32'd1);
    clear = 1'b1; tick(); clear = 1'b0;

    drive(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    tick(); chk("i_range_err", 32'(err), 32'd1);
    drive(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4096);
    tick(); chk("b_range_err", 32'(err), 32'd1);
    drive(3'd4, 7'h37, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'h0000_1001);
    tick(); chk("u_low_err", 32'(err), 32'd1);
    drive(3'd7, 7'h33, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd0);
    tick(); in_valid = 1'b0;
    chk("fmt7_err", 32'(err), 32'd1);
    chk("fmt7_nop", instr, 32'h0000_0013);
    tick();
    chk("range_ec", 32'(err_count), 32'd4);

    out_ready = 1'b0;
    drive(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, $urandom);
    tick(); in_valid = 1'b0;
    chk("held_addr", addr, 32'd16);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_ec", 32'(err_count), 32'd0);
    chk("clr_held_instr", instr, 32'h0020_81B3);
    chk("clr_held_addr", addr, 32'd16);
    chk("clr_held_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    drive(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    tick(); in_valid = 1'b0;
    chk("clr_next_addr", addr, BASE);
    tick();

    out_ready = 1'b0;
    drive(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    tick();
    drive(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd5, 32'd12);
    repeat (3) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_instr", instr, 32'h0050_0093);
      chk("bp_addr", addr, 32'd4);
      tick();
    end
    out_ready = 1'b1;
    tick(); in_valid = 1'b0;
    chk("bp_rel_instr", instr, 32'h0050_A623);
    chk("bp_rel_addr", addr, 32'd8);
    tick();

    drive(3'd6, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (260) tick();
    in_valid = 1'b0;
    tick();
    chk("ec_saturate", 32'(err_count), 32'd255);

    drive(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ec", 32'(err_count), 32'd0);
    chk("midrst_addr", addr, 32'd0);
    in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    drive(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    tick(); in_valid = 1'b0;
    chk("midrst_next_addr", addr, BASE);
    tick();

    repeat (3000) begin
      fmt = 3'($urandom_range(0, 7));
      opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      imm = pick_imm();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 63) == 0);
      tick();
    end
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
